detector_1011_scheduler: RTL and testbench

Shares one serial "1011" pattern detector between two requesters. Each requester submits a parallel word. The block grants requesters round-robin, clears the detector, then shifts the granted word into it MSB-first. It counts detector hits over that word and returns a per-word result through a valid/ready handshake. It sits between the word-level producers and the single-bit fsm_detector_1011 instance.

---
 rtl/detector_1011_scheduler_if.sv | 28 ++
 rtl/detector_1011_scheduler.sv | 118 +++++++++++
 tb/tb_detector_1011_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/detector_1011_scheduler_if.sv
// Word-level handshake bundle for detector_1011_scheduler: two request
// channels into the scheduler and one result channel back out.
interface detector_1011_scheduler_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
);
  logic              req0_valid;
  logic [WORD_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [WORD_W-1:0] req1_data;
  logic              req1_ready;
  logic              res_valid;
  logic              res_ready;
  logic              res_id;
  logic [CNT_W-1:0]  res_count;
  logic              res_hit;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
    output req0_ready, req1_ready, res_valid, res_id, res_count, res_hit
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, res_ready,
    input  req0_ready, req1_ready, res_valid, res_id, res_count, res_hit
  );
endinterface

// File: rtl/detector_1011_scheduler.sv
// Round-robin sharing of one serial "1011" detector between two word
// requesters: clear, shift the word MSB-first, count hits, report.
module detector_1011_scheduler #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  detector_1011_scheduler_if.slave    bus,
  output logic                        det_clr,
  output logic                        det_run,
  input  logic                        det_y,
  output logic                        busy
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    REPORT
  } state_t;

  localparam int                IDX_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0]  idx;
  logic              id;
  logic              last_grant;
  logic [CNT_W-1:0]  count;
  logic              grant_any;
  logic              grant_id;
  logic              sample;

  // Grant only while out of reset so a producer never sees a transfer
  // that the state register is about to discard.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE && reset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_any = 1'b1;
        grant_id  = ~last_grant;
      end else if (bus.req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = CLEAR;
      CLEAR:   state_nxt = SHIFT;
      SHIFT:   if (idx == '0) state_nxt = DRAIN;
      DRAIN:   state_nxt = REPORT;
      REPORT:  if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // det_y lags det_run by one cycle: the first SHIFT cycle still shows the
  // cleared detector, and DRAIN carries the response to the last bit.
  assign sample = ((state == SHIFT) && (idx != IDX_TOP)) || (state == DRAIN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: datapath registers are reset too, so every output reads 0 after reset.
      state      <= IDLE;
      word       <= '0;
      idx        <= '0;
      id         <= 1'b0;
      last_grant <= 1'b1;
      count      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_any) begin
            word       <= grant_id ? bus.req1_data : bus.req0_data;
            id         <= grant_id;
            last_grant <= grant_id;
          end
        end
        CLEAR: begin
          count <= '0;
          idx   <= IDX_TOP;
        end
        SHIFT: begin
          if (idx != '0) idx <= idx - 1'b1;
        end
        default: ;
      endcase
      if (sample && det_y && (count != CNT_MAX)) count <= count + 1'b1;
    end
  end

  assign bus.req0_ready = grant_any && !grant_id;
  assign bus.req1_ready = grant_any && grant_id;
  assign det_clr        = (state == CLEAR);
  assign det_run        = (state == SHIFT) && word[idx];
  assign busy           = (state != IDLE);
  assign bus.res_valid  = (state == REPORT);
  assign bus.res_id     = id;
  assign bus.res_count  = count;
  assign bus.res_hit    = (count != '0);

endmodule

// File: tb/tb_detector_1011_scheduler.sv
// Scoreboard bench for detector_1011_scheduler with an overlapping Moore
// "1011" detector model; a second instance uses a 1-bit counter.
module tb_detector_1011_scheduler;

  typedef struct {
    bit id;
    int count;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  logic det_clr0, det_run0, det_y0, busy0;
  logic det_clr1, det_run1, det_y1, busy1;

  detector_1011_scheduler_if #(.WORD_W(8), .CNT_W(4)) bus0 ();
  detector_1011_scheduler_if #(.WORD_W(8), .CNT_W(1)) bus1 ();

  detector_1011_scheduler #(.WORD_W(8), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .det_clr(det_clr0), .det_run(det_run0), .det_y(det_y0), .busy(busy0)
  );

  detector_1011_scheduler #(.WORD_W(8), .CNT_W(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .det_clr(det_clr1), .det_run(det_run1), .det_y(det_y1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Overlapping Moore detectors: det_y answers for the bit driven last cycle.
  logic [3:0] hist0 = '0;
  logic [3:0] hist1 = '0;
  logic       clr_d1 = 1'b0;
  always @(posedge clk) begin
    hist0  <= det_clr0 ? 4'b0 : {hist0[2:0], det_run0};
    hist1  <= det_clr1 ? 4'b0 : {hist1[2:0], det_run1};
    clr_d1 <= det_clr1;
  end
  assign det_y0 = (hist0 == 4'b1011);
  // Instance 1 sees det_y forced high wherever it must be ignored.
  assign det_y1 = (hist1 == 4'b1011) | det_clr1 | clr_d1 | bus1.res_valid;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t exp_q[$];
  exp_t exp1_q[$];
  int   acc_q[$];
  bit   gap_chk = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor for instance 0: accepts, latency, stability, result scoreboard.
  int   prev_acc = -1;
  bit   held     = 1'b0;
  logic prev_id;
  logic [3:0] prev_cnt;
  logic prev_hit;
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      acc_q.delete();
      prev_acc = -1;
      held     = 1'b0;
    end else begin
      check("one_ready", 32'(bus0.req0_ready && bus0.req1_ready), 0);
      if ((bus0.req0_valid && bus0.req0_ready) || (bus0.req1_valid && bus0.req1_ready)) begin
        acc_q.push_back(cyc);
        if (gap_chk && prev_acc >= 0) check("accept_gap", 32'(cyc - prev_acc), 12);
        prev_acc = cyc;
      end
      if (bus0.res_valid) begin
        check("ready_in_report", 32'(bus0.req0_ready | bus0.req1_ready), 0);
        if (!held) begin
          check("latency_has_accept", 32'(acc_q.size() != 0), 1);
          if (acc_q.size() != 0) check("latency", 32'(cyc - acc_q.pop_front()), 11);
        end else begin
          check("stable_id", 32'(bus0.res_id), 32'(prev_id));
          check("stable_count", 32'(bus0.res_count), 32'(prev_cnt));
          check("stable_hit", 32'(bus0.res_hit), 32'(prev_hit));
        end
        if (bus0.res_ready) begin
          check("result_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("res_id", 32'(bus0.res_id), 32'(e.id));
            check("res_count", 32'(bus0.res_count), 32'(e.count));
            check("res_hit", 32'(bus0.res_hit), 32'(e.count != 0));
          end
        end
      end
      held     = bus0.res_valid && !bus0.res_ready;
      prev_id  = bus0.res_id;
      prev_cnt = bus0.res_count;
      prev_hit = bus0.res_hit;
    end
  end

  // Monitor for instance 1: result scoreboard only.
  always @(negedge clk) begin
    if (reset && bus1.res_valid && bus1.res_ready) begin
      check("cnt1_result_expected", 32'(exp1_q.size() != 0), 1);
      if (exp1_q.size() != 0) begin
        exp_t e;
        e = exp1_q.pop_front();
        check("cnt1_res_id", 32'(bus1.res_id), 32'(e.id));
        check("cnt1_res_count", 32'(bus1.res_count), 32'(e.count));
        check("cnt1_res_hit", 32'(bus1.res_hit), 32'(e.count != 0));
      end
    end
  end

  task automatic pulse_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic send(input bit rid, input logic [7:0] d, input int exp_cnt, input bit chk_run);
    bit got = 1'b0;
    @(posedge clk); #1;
    if (rid) begin
      bus0.req1_valid = 1'b1;
      bus0.req1_data  = d;
    end else begin
      bus0.req0_valid = 1'b1;
      bus0.req0_data  = d;
    end
    exp_q.push_back('{rid, exp_cnt});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rid ? bus0.req1_ready : bus0.req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("accepted", 32'(got), 1);
    @(posedge clk); #1;
    bus0.req0_valid = 1'b0;
    bus0.req1_valid = 1'b0;
    bus0.req0_data  = 8'($urandom);
    bus0.req1_data  = 8'($urandom);
    if (chk_run && got) begin
      @(negedge clk);
      check("clear_clr", 32'(det_clr0), 1);
      check("clear_run", 32'(det_run0), 0);
      for (int b = 7; b >= 0; b--) begin
        @(negedge clk);
        check("det_run_bit", 32'(det_run0), 32'(d[b]));
      end
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy0) begin
        done = 1'b1;
        break;
      end
    end
    check("drained", 32'(done), 1);
  endtask

  task automatic send1(input bit rid, input logic [7:0] d, input int exp_cnt);
    bit got = 1'b0;
    bit seen = 1'b0;
    @(posedge clk); #1;
    if (rid) begin
      bus1.req1_valid = 1'b1;
      bus1.req1_data  = d;
    end else begin
      bus1.req0_valid = 1'b1;
      bus1.req0_data  = d;
    end
    exp1_q.push_back('{rid, exp_cnt});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rid ? bus1.req1_ready : bus1.req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("cnt1_accepted", 32'(got), 1);
    @(posedge clk); #1;
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus1.res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("cnt1_report", 32'(seen), 1);
    repeat (3) @(posedge clk);
    #1;
    bus1.res_ready = 1'b1;
    @(posedge clk); #1;
    bus1.res_ready = 1'b0;
  endtask

  initial begin : stimulus
    bit ok;
    int n;
    bus0.req0_valid = 1'b0; bus0.req0_data = '0;
    bus0.req1_valid = 1'b1; bus0.req1_data = 8'hB0;
    bus0.res_ready  = 1'b1;
    bus1.req0_valid = 1'b0; bus1.req0_data = '0;
    bus1.req1_valid = 1'b0; bus1.req1_data = '0;
    bus1.res_ready  = 1'b0;

    // Reset: a pending request must not see ready while reset is low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", 32'(bus0.req1_ready), 0);
    @(posedge clk); #1;
    bus0.req1_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy0), 0);
    check("rst_res_valid", 32'(bus0.res_valid), 0);
    check("rst_det_clr", 32'(det_clr0), 0);
    check("rst_det_run", 32'(det_run0), 0);
    check("rst_res_count", 32'(bus0.res_count), 0);
    check("rst_res_id", 32'(bus0.res_id), 0);

    // Single words, including overlapping matches and no matches.
    send(1'b0, 8'b1011_0000, 1, 1'b1);
    wait_idle();
    send(1'b1, 8'b1011_0110, 2, 1'b1);
    send(1'b0, 8'h00,        0, 1'b1);
    send(1'b1, 8'hFF,        0, 1'b0);
    send(1'b0, 8'b1101_1011, 2, 1'b0);
    wait_idle();

    // Both requesters valid continuously from reset: 0,1,0,1 every 12 cycles.
    pulse_reset(1);
    gap_chk = 1'b1;
    @(posedge clk); #1;
    bus0.req0_valid = 1'b1; bus0.req0_data = 8'b1011_1011;
    bus0.req1_valid = 1'b1; bus0.req1_data = 8'hB0;
    exp_q.push_back('{1'b0, 2});
    exp_q.push_back('{1'b1, 1});
    exp_q.push_back('{1'b0, 2});
    exp_q.push_back('{1'b1, 1});
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (bus0.req0_ready || bus0.req1_ready) n++;
    end
    check("rr_accepts", 32'(n), 4);
    @(posedge clk); #1;
    bus0.req0_valid = 1'b0;
    bus0.req1_valid = 1'b0;
    wait_idle();
    gap_chk = 1'b0;

    // Back-pressure in REPORT: no grant until the cycle after the handshake.
    @(posedge clk); #1;
    bus0.res_ready = 1'b0;
    send(1'b0, 8'b1101_1011, 2, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus0.res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("report_reached", 32'(ok), 1);
    @(posedge clk); #1;
    bus0.req1_valid = 1'b1;
    bus0.req1_data  = 8'hB0;
    exp_q.push_back('{1'b1, 1});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("held_no_grant", 32'(bus0.req1_ready), 0);
      check("held_valid", 32'(bus0.res_valid), 1);
    end
    @(posedge clk); #1;
    bus0.res_ready = 1'b1;
    @(negedge clk);
    check("handshake_no_grant", 32'(bus0.req1_ready), 0);
    @(negedge clk);
    check("resume_grant", 32'(bus0.req1_ready), 1);
    @(posedge clk); #1;
    bus0.req1_valid = 1'b0;
    wait_idle();

    // Reset during SHIFT bit 3 drops the word.
    send(1'b1, 8'b1011_0000, 1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy0), 0);
    check("abort_det_clr", 32'(det_clr0), 0);
    check("abort_det_run", 32'(det_run0), 0);
    check("abort_res_valid", 32'(bus0.res_valid), 0);
    ok = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus0.res_valid) ok = 1'b1;
    end
    check("abort_no_result", 32'(ok), 0);
    send(1'b0, 8'b1011_0110, 2, 1'b1);
    wait_idle();

    // 1-bit counter saturates; forced det_y in CLEAR/REPORT is ignored.
    send1(1'b0, 8'b1011_0110, 1);
    send1(1'b1, 8'h00,        0);
    send1(1'b0, 8'hFF,        0);
    send1(1'b1, 8'hB0,        1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp1_q.size() == 0 && !busy1) begin
        ok = 1'b1;
        break;
      end
    end
    check("cnt1_drained", 32'(ok), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
